// File: rtl/pa_qparam_loader.sv
// pa_qparam_loader: fetches shift/multiplier/bias words per channel into the
// PE-array requantization buffers. Optional macro: PA_QPARAM_ZERO_FILL_EN.
module pa_qparam_loader #(
   parameter int CH    = 16,
   parameter int IDX_W = 4,
   parameter int AW    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [31:0]      num_ch,
   input  logic [AW-1:0]    shift_base,
   input  logic [AW-1:0]    multi_base,
   input  logic [AW-1:0]    bias_base,
   output logic [AW-1:0]    rd_addr,
   output logic             rd_acq,
   input  logic             rd_rdy,
   input  logic [31:0]      rd_data,
   output logic             buf_wr,
   output logic [1:0]       buf_wr_sel,
   output logic [IDX_W-1:0] buf_idx,
   output logic [31:0]      buf_data,
   output logic             busy,
   output logic             done
);

   localparam int NW = IDX_W + 1;
   localparam logic [NW-1:0] N_MAX = NW'(CH);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FILL  = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      SHIFT = 2'b00,
      MULTI = 2'b01,
      BIAS  = 2'b10
   } grp_t;

   state_t           state, state_nx;
   grp_t             grp, grp_nx, grp_adv;
   logic [IDX_W-1:0] idx, idx_nx, idx_inc;
   logic [NW-1:0]    n, n_nx, n_in;
   logic [AW-1:0]    sb, sb_nx;
   logic [AW-1:0]    mb, mb_nx;
   logic [AW-1:0]    bb, bb_nx;
   logic [AW-1:0]    base_cur, base_adv;
   logic [AW-1:0]    addr_nx;
   logic             acq_nx;
   logic             wr_nx;
   logic [1:0]       sel_nx;
   logic [IDX_W-1:0] bidx_nx;
   logic [31:0]      bdata_nx;
   logic             busy_nx;
   logic             done_nx;
   logic             xfer;
   logic             last;
   logic             adv;

   // Group-dependent helpers: current base, following group and its base.
   always_comb begin
      base_cur = bb;
      grp_adv  = BIAS;
      unique case (grp)
         SHIFT: begin
            base_cur = sb;
            grp_adv  = MULTI;
         end
         MULTI: begin
            base_cur = mb;
            grp_adv  = BIAS;
         end
         default: begin
            base_cur = bb;
            grp_adv  = BIAS;
         end
      endcase
      base_adv = (grp_adv == MULTI) ? mb : bb;
   end

   assign xfer    = rd_acq & rd_rdy;
   assign idx_inc = idx + IDX_W'(1);
   assign last    = ({1'b0, idx} == (n - NW'(1)));
   assign n_in    = (num_ch > 32'(CH)) ? N_MAX : num_ch[NW-1:0];

   // Next-state and next-output logic; every output is registered.
   always_comb begin
      state_nx = state;
      grp_nx   = grp;
      idx_nx   = idx;
      n_nx     = n;
      sb_nx    = sb;
      mb_nx    = mb;
      bb_nx    = bb;
      addr_nx  = rd_addr;
      acq_nx   = rd_acq;
      wr_nx    = 1'b0;
      sel_nx   = buf_wr_sel;
      bidx_nx  = buf_idx;
      bdata_nx = buf_data;
      busy_nx  = busy;
      done_nx  = 1'b0;
      adv      = 1'b0;

      if (abort && state != IDLE) begin
         // Abort wins over rd_rdy: no transfer is taken this cycle.
         state_nx = IDLE;
         acq_nx   = 1'b0;
         busy_nx  = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               acq_nx  = 1'b0;
               busy_nx = 1'b0;
               if (start) begin
                  n_nx    = n_in;
                  sb_nx   = shift_base;
                  mb_nx   = multi_base;
                  bb_nx   = bias_base;
                  grp_nx  = SHIFT;
                  idx_nx  = '0;
                  busy_nx = 1'b1;
                  if (n_in == '0) begin
                     state_nx = DONE;
                  end else begin
                     state_nx = FETCH;
                     acq_nx   = 1'b1;
                     addr_nx  = shift_base;
                  end
               end
            end
            FETCH: begin
               if (xfer) begin
                  wr_nx    = 1'b1;
                  sel_nx   = grp;
                  bidx_nx  = idx;
                  bdata_nx = rd_data;
                  if (!last) begin
                     idx_nx  = idx_inc;
                     addr_nx = base_cur + AW'({idx_inc, 2'b00});
                  end else begin
`ifdef PA_QPARAM_ZERO_FILL_EN
                     if (n != N_MAX) begin
                        state_nx = FILL;
                        idx_nx   = idx_inc;
                        acq_nx   = 1'b0;
                     end else begin
                        adv = 1'b1;
                     end
`else
                     adv = 1'b1;
`endif
                  end
               end
            end
`ifdef PA_QPARAM_ZERO_FILL_EN
            FILL: begin
               acq_nx   = 1'b0;
               wr_nx    = 1'b1;
               sel_nx   = grp;
               bidx_nx  = idx;
               bdata_nx = '0;
               if (idx == IDX_LAST) begin
                  adv = 1'b1;
               end else begin
                  idx_nx = idx_inc;
               end
            end
`endif
            DONE: begin
               state_nx = IDLE;
               acq_nx   = 1'b0;
               busy_nx  = 1'b0;
               done_nx  = 1'b1;
            end
            default: begin
               state_nx = IDLE;
               acq_nx   = 1'b0;
               busy_nx  = 1'b0;
            end
         endcase

         // Group finished: move to the next region or wrap up after biases.
         if (adv) begin
            if (grp == BIAS) begin
               state_nx = DONE;
               acq_nx   = 1'b0;
            end else begin
               state_nx = FETCH;
               grp_nx   = grp_adv;
               idx_nx   = '0;
               acq_nx   = 1'b1;
               addr_nx  = base_adv;
            end
         end
      end
   end

   // State, context and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grp        <= SHIFT;
         idx        <= '0;
         n          <= '0;
         sb         <= '0;
         mb         <= '0;
         bb         <= '0;
         rd_addr    <= '0;
         rd_acq     <= 1'b0;
         buf_wr     <= 1'b0;
         buf_wr_sel <= 2'b00;
         buf_idx    <= '0;
         buf_data   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nx;
         grp        <= grp_nx;
         idx        <= idx_nx;
         n          <= n_nx;
         sb         <= sb_nx;
         mb         <= mb_nx;
         bb         <= bb_nx;
         rd_addr    <= addr_nx;
         rd_acq     <= acq_nx;
         buf_wr     <= wr_nx;
         buf_wr_sel <= sel_nx;
         buf_idx    <= bidx_nx;
         buf_data   <= bdata_nx;
         busy       <= busy_nx;
         done       <= done_nx;
      end
   end

endmodule

// File: tb/tb_pa_qparam_loader.sv
// tb_pa_qparam_loader: directed bench for pa_qparam_loader.
// Expectations follow PA_QPARAM_ZERO_FILL_EN when it is defined.
module tb_pa_qparam_loader;

   localparam logic [31:0] DX = 32'h5A00_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] num_ch = '0;
   logic [31:0] shift_base = '0;
   logic [31:0] multi_base = '0;
   logic [31:0] bias_base = '0;
   logic [31:0] rd_addr;
   logic        rd_acq;
   logic        rd_rdy = 1'b0;
   logic [31:0] rd_data;
   logic        buf_wr;
   logic [1:0]  buf_wr_sel;
   logic [3:0]  buf_idx;
   logic [31:0] buf_data;
   logic        busy;
   logic        done;

   assign rd_data = rd_addr ^ DX;

   pa_qparam_loader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .num_ch     (num_ch),
      .shift_base (shift_base),
      .multi_base (multi_base),
      .bias_base  (bias_base),
      .rd_addr    (rd_addr),
      .rd_acq     (rd_acq),
      .rd_rdy     (rd_rdy),
      .rd_data    (rd_data),
      .buf_wr     (buf_wr),
      .buf_wr_sel (buf_wr_sel),
      .buf_idx    (buf_idx),
      .buf_data   (buf_data),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int acq_cnt = 0;
   int stall_n = 0;
   bit stall_chk = 0;
   bit tog = 0;
   logic        p_acq = 1'b0;
   logic [31:0] p_addr = '0;
   logic [37:0] wr_q[$];
   logic [37:0] exp_q[$];
   int          wr_c[$];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Output monitor, sampled 1 time unit after each rising edge.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (buf_wr) begin
         wr_q.push_back({buf_wr_sel, buf_idx, buf_data});
         wr_c.push_back(cyc);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (rd_acq) acq_cnt++;
      if (stall_chk && p_acq && !rd_rdy) begin
         stall_n++;
         chk("stall_acq", 64'(rd_acq), 64'd1);
         chk("stall_addr", 64'(rd_addr), 64'(p_addr));
      end
      p_acq  = rd_acq;
      p_addr = rd_addr;
   end

   // rd_rdy toggler for the stall test.
   always @(posedge clk) begin
      #2;
      if (tog) rd_rdy = ~rd_rdy;
   end

   task automatic clr();
      wr_q.delete();
      wr_c.delete();
      done_cnt = 0;
      acq_cnt  = 0;
   endtask

   task automatic build_exp(input int n, input logic [31:0] b0,
                            input logic [31:0] b1, input logic [31:0] b2);
      logic [31:0] b;
      logic [1:0]  gs;
      logic [3:0]  is;
      exp_q.delete();
      for (int g = 0; g < 3; g++) begin
         b  = (g == 0) ? b0 : (g == 1) ? b1 : b2;
         gs = 2'(g);
         for (int i = 0; i < n; i++) begin
            is = 4'(i);
            exp_q.push_back({gs, is, (b + 32'(4 * i)) ^ DX});
         end
`ifdef PA_QPARAM_ZERO_FILL_EN
         for (int i = n; i < 16; i++) begin
            is = 4'(i);
            exp_q.push_back({gs, is, 32'h0});
         end
`endif
      end
   endtask

   task automatic cmp_wr(input string tag, input bit contig);
      int m;
      chk({tag, "_cnt"}, 64'(wr_q.size()), 64'(exp_q.size()));
      m = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
      for (int i = 0; i < m; i++)
         chk($sformatf("%s_wr%0d", tag, i), 64'(wr_q[i]), 64'(exp_q[i]));
      if (contig && wr_c.size() > 0)
         chk({tag, "_contig"}, 64'(wr_c[$] - wr_c[0]),
             64'(wr_c.size() - 1));
   endtask

   task automatic pulse(input logic [31:0] nc, input logic [31:0] b0,
                        input logic [31:0] b1, input logic [31:0] b2,
                        output int s);
      num_ch     = nc;
      shift_base = b0;
      multi_base = b1;
      bias_base  = b2;
      start      = 1'b1;
      s          = cyc + 1;
      @(posedge clk);
      #2;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         if (done_cnt > 0) break;
         @(posedge clk);
         #2;
      end
      if (k == budget) chk({tag, "_timeout"}, 64'd0, 64'd1);
      repeat (3) @(posedge clk);
      #2;
   endtask

   task automatic chk_done(input string tag);
      chk({tag, "_dcnt"}, 64'(done_cnt), 64'd1);
      if (wr_c.size() > 0)
         chk({tag, "_dcyc"}, 64'(done_cyc), 64'(wr_c[$] + 1));
   endtask

   initial begin
      int s;
      int k;
      int n0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", {rd_addr, rd_acq, buf_wr, buf_wr_sel, buf_idx,
                        busy, done}, 64'd0);
      chk("rst_data", 64'(buf_data), 64'd0);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #2;

      // Full 16 channels, rd_rdy held high.
      clr();
      rd_rdy = 1'b1;
      pulse(32'd16, 32'h100, 32'h200, 32'h300, s);
      wait_done("t16", 300);
      build_exp(16, 32'h100, 32'h200, 32'h300);
      cmp_wr("t16", 1);
      if (wr_c.size() > 0) chk("t16_lat", 64'(wr_c[0]), 64'(s + 1));
      chk_done("t16");
      chk("t16_busy", 64'(busy), 64'd0);

      // Three channels (fill depends on build).
      clr();
      pulse(32'd3, 32'h1000, 32'h2000, 32'h3000, s);
      wait_done("t3", 300);
      build_exp(3, 32'h1000, 32'h2000, 32'h3000);
      cmp_wr("t3", 1);
      chk_done("t3");

      // Two channels with rd_rdy toggling; address must hold in stalls.
      clr();
      stall_n   = 0;
      stall_chk = 1;
      tog       = 1;
      pulse(32'd2, 32'h400, 32'h500, 32'h600, s);
      wait_done("tog", 300);
      stall_chk = 0;
      tog       = 0;
      #1;
      rd_rdy = 1'b1;
      build_exp(2, 32'h400, 32'h500, 32'h600);
      cmp_wr("tog", 0);
      chk_done("tog");
      chk("tog_stalls", 64'(stall_n > 0), 64'd1);

      // Zero channels: done two cycles after start, no reads.
      clr();
      pulse(32'd0, 32'h700, 32'h800, 32'h900, s);
      wait_done("n0", 50);
      chk("n0_wr", 64'(wr_q.size()), 64'd0);
      chk("n0_acq", 64'(acq_cnt), 64'd0);
      chk("n0_dcnt", 64'(done_cnt), 64'd1);
      chk("n0_dcyc", 64'(done_cyc), 64'(s + 1));

      // Forty channels clamp to sixteen; bases wrap past 2^32.
      clr();
      pulse(32'd40, 32'hFFFF_FFF0, 32'h20, 32'h40, s);
      wait_done("n40", 300);
      build_exp(16, 32'hFFFF_FFF0, 32'h20, 32'h40);
      cmp_wr("n40", 1);
      chk_done("n40");

      // Abort while fetching multiplier idx 5.
      clr();
      pulse(32'd16, 32'h100, 32'h200, 32'h300, s);
      for (k = 0; k < 100; k++) begin
         @(posedge clk);
         #1;
         if (rd_acq && rd_addr == 32'h214) break;
      end
      if (k == 100) chk("ab_reach", 64'd0, 64'd1);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #2;
      abort = 1'b0;
      chk("ab_busy", 64'(busy), 64'd0);
      chk("ab_acq", 64'(rd_acq), 64'd0);
      repeat (6) @(posedge clk);
      #2;
      build_exp(16, 32'h100, 32'h200, 32'h300);
      while (exp_q.size() > 21) exp_q.pop_back();
      cmp_wr("ab", 1);
      chk("ab_done", 64'(done_cnt), 64'd0);

      // Restart after abort begins again at shift idx 0.
      clr();
      pulse(32'd1, 32'hA00, 32'hB00, 32'hC00, s);
      wait_done("re", 200);
      build_exp(1, 32'hA00, 32'hB00, 32'hC00);
      cmp_wr("re", 1);
      if (wr_c.size() > 0) chk("re_lat", 64'(wr_c[0]), 64'(s + 1));
      chk_done("re");

      // Reset mid-fetch.
      clr();
      pulse(32'd16, 32'h100, 32'h200, 32'h300, s);
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mrst_state", {rd_addr, rd_acq, buf_wr, buf_wr_sel, buf_idx,
                         busy, done}, 64'd0);
      chk("mrst_data", 64'(buf_data), 64'd0);
      #1;
      rst = 1'b0;
      n0 = wr_q.size();
      repeat (8) @(posedge clk);
      #2;
      chk("mrst_nowr", 64'(wr_q.size()), 64'(n0));
      chk("mrst_done", 64'(done_cnt), 64'd0);

      // Start while busy is ignored.
      clr();
      pulse(32'd2, 32'hD00, 32'hE00, 32'hF00, s);
      @(posedge clk);
      #2;
      pulse(32'd16, 32'h100, 32'h200, 32'h300, k);
      wait_done("bs", 300);
      repeat (10) @(posedge clk);
      #2;
      build_exp(2, 32'hD00, 32'hE00, 32'hF00);
      cmp_wr("bs", 1);
      chk_done("bs");
      chk("bs_busy", 64'(busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=%0d exp=0", cyc);
      $fatal(1);
   end

endmodule
